// File: rtl/insn_fetch_bus.sv
// insn_fetch_bus: instruction fetch unit that reads instruction words over a
// shared request/grant bus, with an optional zero-wait scratchpad path.
// Build option: define IFB_SPM_EN to enable the scratchpad (SPM) fetch path;
// without it every fetch goes over the bus and SpmRdData is ignored.
module insn_fetch_bus #(
    parameter int WORD_ADDR_W = 30,
    parameter int WORD_DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic [WORD_ADDR_W-1:0] Addr,
    input  logic                   Req,
    input  logic                   Stall,
    input  logic                   Flush,
    output logic [WORD_DATA_W-1:0] Insn,
    output logic                   Busy,
    output logic                   BusReq_,
    input  logic                   BusGrnt_,
    output logic                   BusAs_,
    output logic [WORD_ADDR_W-1:0] BusAddr,
    output logic                   BusRw,
    input  logic [WORD_DATA_W-1:0] BusRdData,
    input  logic                   BusRdy_,
    output logic                   SpmAs_,
    input  logic [WORD_DATA_W-1:0] SpmRdData
);

    localparam logic [WORD_DATA_W-1:0] ISA_NOP = '0;
    localparam logic                   READ    = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACCESS = 2'd2,
        STALL  = 2'd3
    } state_t;

    state_t                   state_reg, state_next;
    logic                     bus_req_n_reg, bus_req_n_next;
    logic                     bus_as_n_reg, bus_as_n_next;
    logic [WORD_ADDR_W-1:0]   bus_addr_reg, bus_addr_next;
    logic [WORD_DATA_W-1:0]   rd_buf_reg, rd_buf_next;
    // Remembers a flush seen after the bus was granted, so the word that
    // eventually arrives is discarded even if Flush has since dropped.
    logic                     flush_pend_reg, flush_pend_next;

    logic                     spm_hit;
    logic [WORD_DATA_W-1:0]   spm_data;
    logic                     flushing;
    logic                     bus_start;

`ifdef IFB_SPM_EN
    // Upper address bits 3'b001 select the scratchpad window.
    assign spm_hit  = (Addr[WORD_ADDR_W-1 -: 3] == 3'b001);
    assign spm_data = SpmRdData;
`else
    logic unused_spm_rd_data;
    assign spm_hit            = 1'b0;
    assign spm_data           = ISA_NOP;
    assign unused_spm_rd_data = ^SpmRdData;
`endif

    assign flushing  = Flush | flush_pend_reg;
    assign bus_start = Req & ~Flush & ~spm_hit;

    // State register; reset aborts any transaction straight back to IDLE.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; once granted, a transaction always runs to BusRdy_.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus_start) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (!BusGrnt_) begin
                    state_next = ACCESS;
                end else if (Flush) begin
                    state_next = IDLE;
                end
            end
            ACCESS: begin
                if (!BusRdy_) begin
                    state_next = (Stall && !flushing) ? STALL : IDLE;
                end
            end
            STALL: begin
                if (Flush || !Stall) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Combinational outputs: fetched word mux, busy flag and SPM strobe.
    always_comb begin
        Insn   = ISA_NOP;
        Busy   = 1'b0;
        SpmAs_ = 1'b1;
        if (reset_) begin
            case (state_reg)
                IDLE: begin
                    if (Req && !Flush) begin
                        if (spm_hit) begin
                            SpmAs_ = 1'b0;
                            Insn   = spm_data;
                        end else begin
                            Busy = 1'b1;
                        end
                    end
                end
                REQ: begin
                    Busy = 1'b1;
                end
                ACCESS: begin
                    if (BusRdy_) begin
                        Busy = 1'b1;
                    end else if (!flushing) begin
                        Insn = BusRdData;
                    end
                end
                STALL: begin
                    if (!Flush) begin
                        Insn = rd_buf_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next values for the registered bus signals, read buffer and flush flag.
    always_comb begin
        bus_req_n_next  = bus_req_n_reg;
        bus_as_n_next   = 1'b1;
        bus_addr_next   = bus_addr_reg;
        rd_buf_next     = rd_buf_reg;
        flush_pend_next = flush_pend_reg;
        case (state_reg)
            IDLE: begin
                flush_pend_next = 1'b0;
                if (bus_start) begin
                    bus_req_n_next = 1'b0;
                    bus_addr_next  = Addr;
                end
            end
            REQ: begin
                if (!BusGrnt_) begin
                    bus_as_n_next   = 1'b0;
                    flush_pend_next = Flush;
                end else if (Flush) begin
                    bus_req_n_next = 1'b1;
                end
            end
            ACCESS: begin
                if (!BusRdy_) begin
                    rd_buf_next     = BusRdData;
                    bus_req_n_next  = 1'b1;
                    flush_pend_next = 1'b0;
                end else if (Flush) begin
                    flush_pend_next = 1'b1;
                end
            end
            STALL: ;
            default: ;
        endcase
    end

    // Registered bus-side state; reset releases the bus immediately.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            bus_req_n_reg  <= 1'b1;
            bus_as_n_reg   <= 1'b1;
            bus_addr_reg   <= '0;
            rd_buf_reg     <= ISA_NOP;
            flush_pend_reg <= 1'b0;
        end else begin
            bus_req_n_reg  <= bus_req_n_next;
            bus_as_n_reg   <= bus_as_n_next;
            bus_addr_reg   <= bus_addr_next;
            rd_buf_reg     <= rd_buf_next;
            flush_pend_reg <= flush_pend_next;
        end
    end

    assign BusReq_ = bus_req_n_reg;
    assign BusAs_  = bus_as_n_reg;
    assign BusAddr = bus_addr_reg;
    assign BusRw   = READ;

endmodule

// File: tb/tb_insn_fetch_bus.sv
// Testbench for insn_fetch_bus: table of bus fetches (wait states, stalls)
// checked through a scoreboard, plus hand-written flush/reset/SPM sequences.
module tb_insn_fetch_bus;

    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic        clk;
    logic        reset_;
    logic [29:0] Addr;
    logic        Req, Stall, Flush;
    logic [31:0] Insn;
    logic        Busy, BusReq_, BusGrnt_, BusAs_, BusRw, BusRdy_, SpmAs_;
    logic [29:0] BusAddr;
    logic [31:0] BusRdData, SpmRdData;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [29:0] addr;
        logic [31:0] data;
        int          gw;   // REQ cycles before grant
        int          rw;   // ACCESS cycles before ready
        int          st;   // STALL-state cycles after completion
    } vec_t;

    typedef struct {
        logic [31:0] insn;
        logic [29:0] addr;
    } exp_t;

    vec_t vecs[5];
    exp_t sb[$];

    insn_fetch_bus dut (
        .clk      (clk),
        .reset_   (reset_),
        .Addr     (Addr),
        .Req      (Req),
        .Stall    (Stall),
        .Flush    (Flush),
        .Insn     (Insn),
        .Busy     (Busy),
        .BusReq_  (BusReq_),
        .BusGrnt_ (BusGrnt_),
        .BusAs_   (BusAs_),
        .BusAddr  (BusAddr),
        .BusRw    (BusRw),
        .BusRdData(BusRdData),
        .BusRdy_  (BusRdy_),
        .SpmAs_   (SpmAs_),
        .SpmRdData(SpmRdData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_cnt(input string name, input int bad);
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: got %0d bad cycles expected 0", name, bad);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Req       = 1'b0;
        Stall     = 1'b0;
        Flush     = 1'b0;
        BusGrnt_  = 1'b1;
        BusRdy_   = 1'b1;
        BusRdData = JUNK;
    endtask

    // One bus fetch with the grant/ready schedule taken from the vector.
    task automatic do_fetch(input vec_t v);
        int   c;
        int   bm, am, rm, im, ac, sm;
        exp_t e;
        c  = v.gw + 2 + v.rw;
        bm = 0; am = 0; rm = 0; im = 0; ac = 0; sm = 0;
        sb.push_back('{insn: v.data, addr: v.addr});
        for (int k = 0; k <= c; k++) begin
            Req       = (k == 0);
            Addr      = (k == 0) ? v.addr : ~v.addr;
            Flush     = 1'b0;
            BusGrnt_  = !(k == v.gw + 1);
            BusRdy_   = !(k == c);
            BusRdData = (k == c) ? v.data : JUNK;
            Stall     = (k == c) && (v.st > 0);
            @(negedge clk);
            if (Busy !== (k < c)) bm++;
            if (BusAs_ !== !(k == v.gw + 2)) am++;
            if (BusReq_ !== !(k >= 1)) rm++;
            if (k >= 1 && BusAddr !== v.addr) ac++;
            if (SpmAs_ !== 1'b1) sm++;
            if (k == c) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_word("insn", Insn, e.insn);
                    check_word("bus_addr", {2'b00, BusAddr}, {2'b00, e.addr});
                end
            end else if (Insn !== NOP) begin
                im++;
            end
            step();
        end
        check_cnt("busy_profile", bm);
        check_cnt("as_profile", am);
        check_cnt("breq_profile", rm);
        check_cnt("addr_stable", ac);
        check_cnt("insn_nop_while_busy", im);
        check_cnt("spm_as_idle", sm);
        for (int s = 1; s <= v.st; s++) begin
            Req       = 1'b1;
            Addr      = v.addr;
            Stall     = (s < v.st);
            BusRdy_   = 1'b1;
            BusRdData = JUNK;
            @(negedge clk);
            check_word("stall_insn", Insn, v.data);
            check_bit("stall_busy", Busy, 1'b0);
            check_bit("stall_breq", BusReq_, 1'b1);
            step();
        end
        idle_inputs();
        @(negedge clk);
        check_word("post_idle_insn", Insn, NOP);
        check_bit("post_idle_busy", Busy, 1'b0);
        check_bit("post_idle_breq", BusReq_, 1'b1);
        step();
    endtask

    initial begin
        vecs[0] = '{addr: 30'h0000_0100, data: 32'h1234_5678, gw: 0, rw: 0, st: 0};
        vecs[1] = '{addr: 30'h0000_02AB, data: 32'h0BAD_F00D, gw: 0, rw: 4, st: 0};
        vecs[2] = '{addr: 30'h0000_3FF0, data: 32'hCAFE_F00D, gw: 0, rw: 0, st: 3};
        vecs[3] = '{addr: 30'h3FFF_FFFF, data: 32'hFFFF_FFFF, gw: 2, rw: 1, st: 1};
        vecs[4] = '{addr: 30'h0000_0000, data: 32'h0000_0001, gw: 1, rw: 0, st: 0};

        reset_    = 1'b0;
        Addr      = '0;
        SpmRdData = 32'hA5A5_A5A5;
        idle_inputs();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_bit("rst_breq", BusReq_, 1'b1);
        check_bit("rst_as", BusAs_, 1'b1);
        check_word("rst_addr", {2'b00, BusAddr}, 32'h0);
        check_bit("rst_busy", Busy, 1'b0);
        check_word("rst_insn", Insn, NOP);
        check_bit("rst_spm_as", SpmAs_, 1'b1);
        check_bit("rst_rw", BusRw, 1'b1);
        reset_ = 1'b1;
        step();

        // Table-driven bus fetches
        for (int i = 0; i < 5; i++) begin
            do_fetch(vecs[i]);
        end

        // Req together with Flush in IDLE: nothing starts
        Req = 1'b1; Flush = 1'b1; Addr = 30'h100;
        @(negedge clk);
        check_bit("idle_flush_busy", Busy, 1'b0);
        check_word("idle_flush_insn", Insn, NOP);
        step();
        idle_inputs();
        @(negedge clk);
        check_bit("idle_flush_breq", BusReq_, 1'b1);
        step();

        // Flush in REQ before grant
        Req = 1'b1; Addr = 30'h55;
        step();
        Req = 1'b0; Flush = 1'b1;
        @(negedge clk);
        check_bit("freq_breq_low", BusReq_, 1'b0);
        step();
        Flush = 1'b0;
        @(negedge clk);
        check_bit("freq_breq_released", BusReq_, 1'b1);
        check_bit("freq_as", BusAs_, 1'b1);
        check_word("freq_insn", Insn, NOP);
        check_bit("freq_busy", Busy, 1'b0);
        step();
        BusGrnt_ = 1'b0;
        step();
        BusGrnt_ = 1'b1;
        @(negedge clk);
        check_bit("freq_no_as_late_grant", BusAs_, 1'b1);
        step();

        // Flush in ACCESS: completes on BusRdy_, delivers NOP, ignores Stall
        Req = 1'b1; Addr = 30'h77;
        step();
        Req = 1'b0; BusGrnt_ = 1'b0;
        step();
        BusGrnt_ = 1'b1; Flush = 1'b1;
        @(negedge clk);
        check_bit("facc_as", BusAs_, 1'b0);
        check_bit("facc_busy", Busy, 1'b1);
        step();
        Flush = 1'b0;
        @(negedge clk);
        check_bit("facc_wait_busy", Busy, 1'b1);
        step();
        BusRdy_ = 1'b0; BusRdData = 32'h55AA_55AA; Stall = 1'b1;
        @(negedge clk);
        check_word("facc_insn", Insn, NOP);
        check_bit("facc_done_busy", Busy, 1'b0);
        step();
        BusRdy_ = 1'b1; BusRdData = JUNK;
        @(negedge clk);
        check_word("facc_idle_insn", Insn, NOP);
        check_bit("facc_idle_breq", BusReq_, 1'b1);
        step();
        idle_inputs();

        // Flush while in STALL
        Req = 1'b1; Addr = 30'h99;
        step();
        Req = 1'b0; BusGrnt_ = 1'b0;
        step();
        BusGrnt_ = 1'b1; BusRdy_ = 1'b0; BusRdData = 32'h1357_9BDF; Stall = 1'b1;
        @(negedge clk);
        check_word("fstall_done_insn", Insn, 32'h1357_9BDF);
        step();
        BusRdy_ = 1'b1; BusRdData = JUNK; Flush = 1'b1;
        @(negedge clk);
        check_word("fstall_insn", Insn, NOP);
        check_bit("fstall_busy", Busy, 1'b0);
        step();
        Flush = 1'b0;
        @(negedge clk);
        check_word("fstall_idle_insn", Insn, NOP);
        step();
        idle_inputs();

        // Asynchronous reset in the middle of ACCESS
        Req = 1'b1; Addr = 30'h1C0;
        step();
        Req = 1'b0; BusGrnt_ = 1'b0;
        step();
        BusGrnt_ = 1'b1;
        #2;
        reset_ = 1'b0;
        #1;
        check_bit("arst_breq", BusReq_, 1'b1);
        check_bit("arst_as", BusAs_, 1'b1);
        check_word("arst_addr", {2'b00, BusAddr}, 32'h0);
        check_bit("arst_busy", Busy, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset_ = 1'b1;
        step();
        do_fetch('{addr: 30'h0C0, data: 32'h600D_CAFE, gw: 0, rw: 0, st: 0});

        // Scratchpad window
`ifdef IFB_SPM_EN
        Req = 1'b1; Addr = {3'b001, 27'h40}; SpmRdData = 32'hA5A5_A5A5;
        @(negedge clk);
        check_bit("spm_as", SpmAs_, 1'b0);
        check_word("spm_insn", Insn, 32'hA5A5_A5A5);
        check_bit("spm_busy", Busy, 1'b0);
        step();
        Req = 1'b0;
        @(negedge clk);
        check_bit("spm_breq", BusReq_, 1'b1);
        check_bit("spm_as_off", SpmAs_, 1'b1);
        step();
`else
        SpmRdData = 32'hA5A5_A5A5;
        do_fetch('{addr: {3'b001, 27'h40}, data: 32'h1234_5678, gw: 0, rw: 0, st: 0});
`endif

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d entries expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/insn_fetch_bus.md
INSN_FETCH_BUS -- requirements
Module: insn_fetch_bus

Interface
REQ-001 clk  in  1  sole clock; all state updates on posedge clk.
REQ-002 reset_  in  1  asynchronous, active-low reset (`RESET_EDGE reset_ / `RESET_ENABLE).
REQ-003 Addr  in  `WORD_ADDR_BUS  word address of instruction to fetch (the current fetch PC).
REQ-004 Req  in  1  fetch request, active-high; sampled only in IDLE.
REQ-005 Stall  in  1  pipeline stall, active-high; the fetched word is held while asserted.
REQ-006 Flush  in  1  pipeline flush, active-high.
REQ-007 Insn  out  `WORD_DATA_BUS  fetched instruction word to the IF register (combinational mux).
REQ-008 Busy  out  1  fetch-not-complete, active-high; drives the pipeline stall controller (combinational).
REQ-009 BusReq_  out  1  bus request to arbiter, active-low, registered.
REQ-010 BusGrnt_  in  1  bus grant, active-low.
REQ-011 BusAs_  out  1  address strobe, active-low, registered, one cycle wide.
REQ-012 BusAddr  out  `WORD_ADDR_BUS  bus address, registered.
REQ-013 BusRw  out  1  tied to read (`READ).
REQ-014 BusRdData  in  `WORD_DATA_BUS  bus read data, valid when BusRdy_ is low.
REQ-015 BusRdy_  in  1  bus ready, active-low.
REQ-016 SpmAs_  out  1  scratchpad address strobe, active-low, combinational.
REQ-017 SpmRdData  in  `WORD_DATA_BUS  scratchpad read data, same-cycle.

Function
REQ-018 FSM states SHALL be IDLE, REQ, ACCESS, STALL; state and read buffer RdBuf are registered.
REQ-019 IDLE, Req=1, Flush=0, bus path: assert BusReq_=0, latch BusAddr=Addr, go REQ; Busy=1 that cycle.
REQ-020 IDLE, Req=0 or Flush=1: stay IDLE, Busy=0, Insn=`ISA_NOP, no bus activity.
REQ-021 REQ, BusGrnt_=0: drive BusAs_=0 for exactly one cycle, go ACCESS; Busy=1.
REQ-022 REQ, Flush=1 before grant: release BusReq_=1, go IDLE, Insn=`ISA_NOP; a granted transaction is never abandoned.
REQ-023 ACCESS, BusRdy_=1: hold, Busy=1, BusAs_=1.
REQ-024 ACCESS, BusRdy_=0: Insn=BusRdData that cycle, Busy=0, RdBuf<=BusRdData, BusReq_<=1; next state STALL if Stall=1 else IDLE.
REQ-025 Flush=1 while in ACCESS: transaction completes per REQ-024, but Insn=`ISA_NOP on completion and next state is IDLE.
REQ-026 STALL: Insn=RdBuf, Busy=0; Stall=0 -> IDLE; Flush=1 -> IDLE with Insn=`ISA_NOP.
REQ-027 Minimum bus-path latency: Req to Insn valid (Busy low) = 3 cycles with grant and ready each asserted on their first eligible cycle.
REQ-028 BusAddr SHALL remain stable from REQ entry until return to IDLE.

Reset
REQ-029 While reset_ low: state=IDLE, BusReq_=1, BusAs_=1, BusAddr=0, RdBuf=`ISA_NOP.
REQ-030 Reset asserted mid-transaction aborts immediately to the values of REQ-029; no completion is owed to the bus.
REQ-031 Outputs after reset: Busy=0, Insn=`ISA_NOP, SpmAs_=1.

Configuration
REQ-032 Macro IFB_SPM_EN: when defined, Addr with upper 3 bits == 3'b001 is an SPM hit: in IDLE with Req=1, Flush=0, SpmAs_=0, Insn=SpmRdData, Busy=0, zero-wait, no state change, no bus request.
REQ-033 Without IFB_SPM_EN: SpmAs_ held 1, SpmRdData ignored, every fetch takes the bus path.

Verification
REQ-034 Bus fetch: Req=1, Addr=0x100, grant next cycle, BusRdy_=0 with BusRdData=0x12345678 one cycle after BusAs_ -> Busy 1,1,0; Insn=0x12345678 on the third cycle; BusAddr=0x100.
REQ-035 Wait states: BusRdy_ held high 4 cycles in ACCESS -> Busy stays 1 throughout, BusAs_ low exactly one cycle, BusAddr unchanged.
REQ-036 Stall hold: Stall=1 at completion of read 0xCAFEF00D, held 3 cycles -> Insn=0xCAFEF00D all 3 cycles, Busy=0, no new BusReq_.
REQ-037 Flush races: Flush in REQ before grant -> BusReq_ deasserted next cycle, no BusAs_; Flush in ACCESS -> wait for BusRdy_, Insn=`ISA_NOP, return IDLE.
REQ-038 IFB_SPM_EN build: Addr with upper bits 001, SpmRdData=0xA5A5A5A5 -> SpmAs_=0, Insn=0xA5A5A5A5, Busy=0 same cycle, BusReq_ stays 1; non-SPM build -> bus path as REQ-034.
REQ-039 Reset mid-ACCESS: reset_ low -> BusReq_=1, BusAs_=1, state IDLE asynchronously; after release, new Req starts cleanly.
